// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Core and host share one access per cycle; read/error responses return one cycle after grant.

module mem_arbiter_resp #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          gnt,
  input  logic          we,
  input  logic          legal,
  input  logic [DW-1:0] rd_in,
  output logic          rvalid,
  output logic          err,
  output logic [DW-1:0] rdata
);
  // rdata only moves on this port's own read or error response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= gnt & legal & ~we;
      err    <= gnt & ~legal;
      if (gnt & ~legal)   rdata <= '0;
      else if (gnt & ~we) rdata <= rd_in;
    end
  end
endmodule

module mem_arbiter #(
  parameter int data_size    = 64,
  parameter int address_size = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 c_req,
  input  logic                 c_we,
  input  logic [63:0]          c_addr,
  input  logic [data_size-1:0] c_wdata,
  output logic                 c_gnt,
  output logic                 c_rvalid,
  output logic [data_size-1:0] c_rdata,
  output logic                 c_err,
  input  logic                 h_req,
  input  logic                 h_we,
  input  logic [63:0]          h_addr,
  input  logic [data_size-1:0] h_wdata,
  output logic                 h_gnt,
  output logic                 h_rvalid,
  output logic [data_size-1:0] h_rdata,
  output logic                 h_err,
  output logic [63:0]          mem_address,
  output logic [data_size-1:0] mem_data_in,
  input  logic [data_size-1:0] mem_data_out,
  output logic                 mem_write_enable
);
  localparam int NP = 2;  // port 0 = core, port 1 = host

  logic [NP-1:0]                req, we, gnt, rvalid, err;
  logic [NP-1:0][63:0]          addr;
  logic [NP-1:0][data_size-1:0] wdata, rdata;
  logic                         last;  // 1 = host won most recently
  logic [63:0]                  sel_addr;
  logic [data_size-1:0]         sel_wdata;
  logic                         sel_we, legal;

  assign req   = {h_req, c_req};
  assign we    = {h_we, c_we};
  assign addr  = {h_addr, c_addr};
  assign wdata = {h_wdata, c_wdata};

  // grants are forced low while reset is asserted
  always_comb begin
    gnt = '0;
    if (rst_n) begin
      if (req[0] && (!req[1] || last)) gnt[0] = 1'b1;
      else if (req[1])                 gnt[1] = 1'b1;
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int p = 0; p < NP; p++) begin
      if (gnt[p]) begin
        sel_addr  = addr[p];
        sel_wdata = wdata[p];
        sel_we    = we[p];
      end
    end
  end

  assign legal            = (sel_addr[63:address_size+2] == '0) && (sel_addr[1:0] == 2'b00);
  assign mem_address      = {{(64-address_size){1'b0}}, sel_addr[address_size+1:2]};
  assign mem_data_in      = sel_wdata;
  assign mem_write_enable = (|gnt) & sel_we & legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last <= 1'b1;
    else if (|gnt) last <= gnt[1];
  end

  for (genvar p = 0; p < NP; p++) begin : g_port
    mem_arbiter_resp #(.DW(data_size)) u_resp (
      .clk    (clk),
      .rst_n  (rst_n),
      .gnt    (gnt[p]),
      .we     (we[p]),
      .legal  (legal),
      .rd_in  (mem_data_out),
      .rvalid (rvalid[p]),
      .err    (err[p]),
      .rdata  (rdata[p])
    );
  end

  assign c_gnt    = gnt[0];
  assign h_gnt    = gnt[1];
  assign c_rvalid = rvalid[0];
  assign h_rvalid = rvalid[1];
  assign c_err    = err[0];
  assign h_err    = err[1];
  assign c_rdata  = rdata[0];
  assign h_rdata  = rdata[1];
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then randomized requesters, checked
// against a transaction-level model of grants, responses and memory contents.

module tb_mem_arbiter;
  localparam int DW = 64, AW = 5, DEPTH = 32;

  logic clk = 1'b0, rst_n = 1'b0;
  logic c_req = 1'b0, c_we = 1'b0, h_req = 1'b0, h_we = 1'b0;
  logic [63:0] c_addr = '0, h_addr = '0;
  logic [DW-1:0] c_wdata = '0, h_wdata = '0;
  logic c_gnt, c_rvalid, c_err, h_gnt, h_rvalid, h_err, mem_write_enable;
  logic [DW-1:0] c_rdata, h_rdata, mem_data_in, mem_data_out;
  logic [63:0] mem_address;

  int errors = 0, checks = 0;

  // environment memory (stands in for Memory) with deterministic preload
  logic [DW-1:0] env_mem [DEPTH];
  logic env_ready = 1'b0;
  always @(posedge clk) begin
    if (!env_ready) begin
      for (int i = 0; i < DEPTH; i++) env_mem[i] <= 64'hA5A5_0000_0000_0000 | 64'(i);
      env_ready <= 1'b1;
    end else if (mem_write_enable) env_mem[mem_address[4:0]] <= mem_data_in;
  end
  assign mem_data_out = env_mem[mem_address[4:0]];

  always #5 clk = ~clk;

  mem_arbiter #(.data_size(DW), .address_size(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata), .h_err(h_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_write_enable(mem_write_enable)
  );

  // reference model state
  logic [DW-1:0] ref_mem [DEPTH];
  int            m_last;          // 0 = core, 1 = host
  int            win;             // winner of the latest step, -1 none
  logic [1:0]    e_rv, e_err;
  logic [DW-1:0] e_rd [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last = 1;
    e_rv   = '0;
    e_err  = '0;
    e_rd[0] = '0;
    e_rd[1] = '0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_c_gnt"},    64'(c_gnt), 64'd0);
    chk({tag, "_h_gnt"},    64'(h_gnt), 64'd0);
    chk({tag, "_c_rvalid"}, 64'(c_rvalid), 64'd0);
    chk({tag, "_h_rvalid"}, 64'(h_rvalid), 64'd0);
    chk({tag, "_c_err"},    64'(c_err), 64'd0);
    chk({tag, "_h_err"},    64'(h_err), 64'd0);
    chk({tag, "_c_rdata"},  c_rdata, 64'd0);
    chk({tag, "_h_rdata"},  h_rdata, 64'd0);
    chk({tag, "_mem_we"},   64'(mem_write_enable), 64'd0);
    chk({tag, "_mem_addr"}, mem_address, 64'd0);
  endtask

  // one cycle: called just after a negedge with requests already driven
  task automatic step();
    logic wr, legal;
    logic [63:0] a;
    logic [DW-1:0] wd;
    int idx;
    win = -1;
    if (c_req && h_req) win = (m_last == 0) ? 1 : 0;
    else if (c_req)     win = 0;
    else if (h_req)     win = 1;
    #1;
    wr    = (win == 1) ? h_we : c_we;
    a     = (win == 1) ? h_addr : c_addr;
    wd    = (win == 1) ? h_wdata : c_wdata;
    legal = (a[63:AW+2] == '0) && (a[1:0] == 2'b00);
    idx   = int'(a[AW+1:2]);
    chk("c_gnt", 64'(c_gnt), 64'(win == 0));
    chk("h_gnt", 64'(h_gnt), 64'(win == 1));
    chk("mem_we", 64'(mem_write_enable), 64'(win >= 0 && wr && legal));
    if (win < 0) chk("mem_addr_idle", mem_address, 64'd0);
    e_rv  = '0;
    e_err = '0;
    if (win >= 0) begin
      if (!legal)   begin e_err[win] = 1'b1; e_rd[win] = '0; end
      else if (!wr) begin e_rv[win] = 1'b1; e_rd[win] = ref_mem[idx]; end
      else ref_mem[idx] = wd;
      m_last = win;
    end
    @(posedge clk);
    #1;
    chk("c_rvalid", 64'(c_rvalid), 64'(e_rv[0]));
    chk("h_rvalid", 64'(h_rvalid), 64'(e_rv[1]));
    chk("c_err",    64'(c_err),    64'(e_err[0]));
    chk("h_err",    64'(h_err),    64'(e_err[1]));
    chk("c_rdata",  c_rdata, e_rd[0]);
    chk("h_rdata",  h_rdata, e_rd[1]);
    @(negedge clk);
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    a = 64'($urandom_range(DEPTH-1)) << 2;
    case ($urandom_range(7))
      0: a[7 + $urandom_range(56)] = 1'b1;
      1: a[1:0] = 2'($urandom_range(3, 1));
      default: ;
    endcase
    return a;
  endfunction

  initial begin
    logic [DW-1:0] hword;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;

    // both ports read continuously from reset: core first, then alternate
    c_req = 1; c_we = 0; c_addr = 64'h10;
    h_req = 1; h_we = 0; h_addr = 64'h20;
    repeat (6) step();
    h_req = 0;

    // core write then read-back
    c_we = 1; c_addr = 64'h10; c_wdata = 64'hDEAD_BEEF_0000_0001;
    step();
    c_we = 0;
    step();
    chk("wr_rd_data", c_rdata, 64'hDEAD_BEEF_0000_0001);
    c_req = 0;

    // host illegal writes: out of range and misaligned
    h_req = 1; h_we = 1; h_wdata = 64'h1111_2222_3333_4444; h_addr = 64'h80;
    step();
    h_addr = 64'h06;
    step();
    h_req = 0;
    chk("illegal_mem0", env_mem[0], ref_mem[0]);
    chk("illegal_mem1", env_mem[1], ref_mem[1]);

    // make core the last winner, then conflict on address 0x04
    c_req = 1; c_we = 0; c_addr = 64'h08;
    step();
    c_addr = 64'h04;
    h_req = 1; h_we = 1; h_addr = 64'h04; h_wdata = 64'h0BAD_CAFE_1234_5678;
    step();
    h_req = 0;
    step();
    chk("conflict_rd", c_rdata, 64'h0BAD_CAFE_1234_5678);
    c_req = 0;

    // reset while a core read response is pending
    c_req = 1; c_we = 0; c_addr = 64'h10;
    #1 chk("prerst_gnt", 64'(c_gnt), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("midrst");
    model_reset();
    c_req = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();
    c_req = 1; c_addr = 64'h0C;
    h_req = 1; h_we = 0; h_addr = 64'h14;
    step();
    chk("postrst_winner", 64'(win), 64'd0);
    step();
    c_req = 0; h_req = 0;

    // host read of 0x00, then core-only traffic must not disturb h_rdata
    h_req = 1; h_we = 0; h_addr = 64'h00;
    step();
    hword = ref_mem[0];
    h_req = 0;
    c_req = 1;
    for (int n = 0; n < 5; n++) begin
      c_we = 1'($urandom_range(1)); c_addr = 64'(n) << 2; c_wdata = {$urandom, $urandom};
      step();
    end
    c_req = 0;
    chk("h_rdata_hold", h_rdata, hword);

    // randomized requesters that hold their request until granted
    for (int n = 0; n < 400; n++) begin
      if (!c_req && $urandom_range(2) != 0) begin
        c_req = 1; c_we = 1'($urandom_range(1)); c_addr = rand_addr(); c_wdata = {$urandom, $urandom};
      end
      if (!h_req && $urandom_range(2) != 0) begin
        h_req = 1; h_we = 1'($urandom_range(1)); h_addr = rand_addr(); h_wdata = {$urandom, $urandom};
      end
      step();
      if (win == 0)      c_req = 0;
      else if (win == 1) h_req = 0;
    end
    c_req = 0; h_req = 0;
    for (int i = 0; i < DEPTH; i++) chk("final_mem", env_mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares the single-port data `Memory` between the eBPF core load/store unit ("c" port) and the host loader ("h" port). It sits directly in front of `Memory` and drives its address, data and write-enable. Each cycle it grants at most one request and range-checks the address. Read data comes back registered one cycle after the grant, with an error pulse for illegal addresses.

## Interface
- `data_size`, 64: data width; must match `Memory`.
- `address_size`, 5: `Memory` word-index width; depth = 2**address_size words.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `c_req` in 1: core request; held until `c_gnt`.
- `c_we` in 1: core write (1) / read (0).
- `c_addr` in 64: core byte address.
- `c_wdata` in data_size: core write data.
- `c_gnt` out 1: core request accepted this cycle.
- `c_rvalid` out 1: core read data valid; one-cycle pulse.
- `c_rdata` out data_size: core read data.
- `c_err` out 1: core access rejected; one-cycle pulse.
- `h_req`, `h_we`, `h_addr`, `h_wdata`, `h_gnt`, `h_rvalid`, `h_rdata`, `h_err`: host port, identical semantics.
- `mem_address` out 64: to `Memory.address`.
- `mem_data_in` out data_size: to `Memory.data_in`.
- `mem_data_out` in data_size: from `Memory.data_out` (combinational read).
- `mem_write_enable` out 1: to `Memory.write_enable`.

## Operation
- **Arbitration:** `c_gnt` and `h_gnt` are combinational from the requests and the `last` register.
  - Only one port requesting: that port is granted.
  - Both ports requesting: the port not equal to `last` is granted.
  - `last` updates to the granted port on each grant.
- **Mux:** `mem_address`, `mem_data_in` and the write qualifier come from the granted port. With no grant, `mem_address` = 0 and `mem_write_enable` = 0.
- **Legal address:** `addr[63:address_size+2]` == 0 and `addr[1:0]` == 0. Word index = `addr[address_size+1:2]`.
- **Granted legal write:** `mem_write_enable` = 1 in the grant cycle. No rvalid and no err follow.
- **Granted legal read:** the selected port's rdata register captures `mem_data_out` at the grant edge. That port's rvalid pulses the next cycle.
- **Granted illegal access (read or write):** `mem_write_enable` stays 0. The port's err pulses the next cycle, and its rdata is loaded with 0.
- **rdata holding:** each port's rdata holds its value until that port's next read or err response. The other port's traffic never changes it.
- **State:** `last` (1 bit), a per-port response-pending flag, and a per-port error flag. There is no multi-cycle FSM: `IDLE`/`SERVE` is collapsed into the per-cycle grant.

## Timing
- **Reset** (`rst_n` low, async):
  - all gnt/rvalid/err outputs = 0;
  - `c_rdata` = `h_rdata` = 0;
  - `mem_write_enable` = 0;
  - `last` = host, so the core wins the first conflict.
- **Read latency:** grant in cycle N → rvalid/rdata in cycle N+1.
- **Throughput:** one access per cycle total, so back-to-back grants are allowed. A port held with `req` high and no competitor is granted every cycle.
- **Conflict:** the loser keeps `req` high and is granted the next cycle. Maximum wait is 1 cycle.
- **Request hold:** requesters must hold `req`/`we`/`addr`/`wdata` stable until gnt. The arbiter does not latch request fields.
- **Simultaneous events:** a port's response from grant N and its new grant in N+1 coexist. The response refers to N.
- **Reset mid-operation:** a pending response is discarded, and no rvalid/err follows reset release. A write already clocked into `Memory` stays.
- **Write ordering:** a read of an address written in the previous cycle returns the new data, because `Memory` read is combinational after the write edge.

## Test plan
- Reset, then core writes 0xDEAD_BEEF_0000_0001 to addr 0x10, then reads 0x10.
  - Required: `c_gnt` on both; `mem_write_enable` = 1 only in the write cycle; `c_rvalid` = 1 one cycle after the read grant with `c_rdata` = 0xDEAD_BEEF_0000_0001.
- Both ports request reads continuously from reset.
  - Required: grants alternate c, h, c, h; each rvalid follows its grant by 1 cycle; no cycle has both gnts.
- Host writes addr 0x80 (out of range for address_size=5) and addr 0x06 (misaligned).
  - Required: `h_gnt` = 1; `mem_write_enable` = 0; `h_err` pulses next cycle; `h_rdata` = 0; memory contents unchanged.
- Core reads 0x04 while host writes 0x04 in the same cycle, with `last` = core.
  - Required: host granted first and writes; core granted next cycle and reads the host data.
- Core read granted, `rst_n` pulled low in the following cycle before rvalid.
  - Required: all outputs 0 immediately; no `c_rvalid` after release; first post-reset conflict goes to the core.
- Host read of 0x00 followed by core-only traffic for 5 cycles.
  - Required: `h_rdata` holds the 0x00 word throughout; `h_rvalid` pulses exactly once.
